circle_ctrl: RTL
================

CIRCLE_CTRL -- requirements
Module: circle_ctrl

Interface
REQ-001 SHALL expose parameter OFFSET_X_DW, default 9, signed width of offset_x input.
REQ-002 SHALL expose parameter OFFSET_Y_DW, default 8, signed width of offset_y input.
REQ-003 SHALL expose parameter CRIT_DW, default 9, signed width of crit input.
REQ-004 SHALL have ports as follows; clock is clk and reset is resetn, synchronous, active-low.
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- start  input  1  level request to draw one circle
- done  output  1  circle complete; held until start low
- offset_x  input  OFFSET_X_DW  signed datapath x offset register
- offset_y  input  OFFSET_Y_DW  signed datapath y offset register
- crit  input  CRIT_DW  signed datapath criterion register
- octant_sel  output  3  octant mux select, 0..7
- plot_en  output  1  pixel-write qualifier; ANDed with datapath on-screen plot at top
- load_x_init, load_y_init, load_crit  output  1 each  datapath initial loads
- dec_x, inc_y  output  1 each  next-offset compute controls
- load_x_next, load_y_next, calc_crit  output  1 each  datapath update strobes

Function
REQ-005 SHALL implement Moore FSM states IDLE, INIT, CHECK, DRAW, CALC, LOAD, DONE; all outputs decoded from registered state and 3-bit octant counter.
REQ-006 IDLE: all outputs 0; start=1 -> INIT next cycle.
REQ-007 INIT (1 cycle): load_x_init=load_y_init=load_crit=1 -> CHECK.
REQ-008 CHECK (1 cycle): signed compare offset_y <= offset_x (sign-extended to common width) -> DRAW with octant counter 0, else -> DONE.
REQ-009 DRAW: plot_en=1, octant_sel=counter; counter increments each cycle; after sel 7 -> CALC (8 cycles).
REQ-010 CALC (1 cycle): inc_y=1; dec_x=1 iff crit > 0 (signed) -> LOAD.
REQ-011 LOAD (1 cycle): load_x_next=load_y_next=calc_crit=1 -> CHECK.
REQ-012 DONE: done=1; start=0 -> IDLE; start held 1 -> remain DONE (no auto-restart).
REQ-013 Latency: done asserts 3 + 11*N cycles after the edge sampling start in IDLE, N = DRAW iterations.
REQ-014 start changes outside IDLE/DONE SHALL be ignored; drawing completes.
REQ-015 Exactly one control strobe group active per cycle; no strobe asserted outside its state.

Reset
REQ-016 resetn=0 at any clock edge, including mid-DRAW, SHALL force IDLE, counter 0, all outputs 0 next cycle.
REQ-017 Reset SHALL take priority over start.

Configuration
REQ-018 Macro CIRCLE_CTRL_OCT_SKIP_EN defined: DRAW visits only sel {0,1,3,5} when offset_y==0 (offset_x!=0), only {0,2,4,6} when offset_y==offset_x (!=0), only {0} when both 0; DRAW length becomes 4/4/1 cycles, and REQ-013 latency reduces accordingly.
REQ-019 Macro undefined: DRAW always visits all 8 octants in order 0..7.

Structure
REQ-020 Package circle_pkg SHALL hold state enum, octant select constants OCT1..OCT8 (0..7), default widths.
REQ-021 No sub-module; single FSM plus octant counter.

Verification
REQ-022 Radius 0 (datapath x=0,y=0,crit=1): start pulse -> 8 plot_en cycles sel 0..7, done at cycle 14 (macro off).
REQ-023 Radius 3: crit -2 then 1 then 2 -> dec_x pattern 0,1,1; 3 iterations; done at cycle 36; plot_en high 24 cycles.
REQ-024 resetn low during DRAW sel 4 -> next cycle IDLE, all outputs 0; subsequent start redraws from INIT.
REQ-025 start held high through DONE for 5 cycles -> done stays 1, no INIT; start low -> IDLE next cycle.
REQ-026 Macro on, radius 3 -> iteration 1 visits sel 0,1,3,5; iteration 3 (x=y=2) visits 0,2,4,6; done at cycle 28.

Source files
------------

// File: rtl/circle_pkg.sv
// ============================================================================
//  circle_pkg -- shared types and constants for the circle drawing controller
//  Revision: 1.0
// ============================================================================
`default_nettype none

package circle_pkg;

   localparam int DEF_OFFSET_X_DW = 9;
   localparam int DEF_OFFSET_Y_DW = 8;
   localparam int DEF_CRIT_DW     = 9;

   localparam logic [2:0] OCT1 = 3'd0;
   localparam logic [2:0] OCT2 = 3'd1;
   localparam logic [2:0] OCT3 = 3'd2;
   localparam logic [2:0] OCT4 = 3'd3;
   localparam logic [2:0] OCT5 = 3'd4;
   localparam logic [2:0] OCT6 = 3'd5;
   localparam logic [2:0] OCT7 = 3'd6;
   localparam logic [2:0] OCT8 = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DRAW  = 3'd3,
      ST_CALC  = 3'd4,
      ST_LOAD  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Which subset of octants a DRAW pass visits when duplicate pixels are skipped
   typedef enum logic [1:0] {
      MODE_FULL   = 2'd0,
      MODE_AXIS   = 2'd1,
      MODE_DIAG   = 2'd2,
      MODE_ORIGIN = 2'd3
   } oct_mode_t;

   function automatic oct_mode_t oct_mode(input logic x_zero, input logic y_zero,
                                          input logic xy_eq);
      if (x_zero && y_zero) return MODE_ORIGIN;
      if (y_zero)           return MODE_AXIS;
      if (xy_eq)            return MODE_DIAG;
      return MODE_FULL;
   endfunction

endpackage

`default_nettype wire

// File: rtl/circle_ctrl.sv
// ============================================================================
//  circle_ctrl -- Moore FSM sequencing a midpoint-circle datapath, 8 octants
//  Optional: CIRCLE_CTRL_OCT_SKIP_EN skips duplicate octants on axes/diagonal
//  Revision: 1.0
// ============================================================================
`default_nettype none

module circle_ctrl
   import circle_pkg::*;
#(
   parameter int OFFSET_X_DW = DEF_OFFSET_X_DW,
   parameter int OFFSET_Y_DW = DEF_OFFSET_Y_DW,
   parameter int CRIT_DW     = DEF_CRIT_DW
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          start,
   output logic                          done,
   input  logic signed [OFFSET_X_DW-1:0] offset_x,
   input  logic signed [OFFSET_Y_DW-1:0] offset_y,
   input  logic signed [CRIT_DW-1:0]     crit,
   output logic [2:0]                    octant_sel,
   output logic                          plot_en,
   output logic                          load_x_init,
   output logic                          load_y_init,
   output logic                          load_crit,
   output logic                          dec_x,
   output logic                          inc_y,
   output logic                          load_x_next,
   output logic                          load_y_next,
   output logic                          calc_crit
);

   localparam int CMP_DW = (OFFSET_X_DW > OFFSET_Y_DW) ? OFFSET_X_DW : OFFSET_Y_DW;

   state_t     state_q, state_d;
   logic [2:0] oct_q, oct_d;
   logic [2:0] oct_last, oct_next;

   logic signed [CMP_DW-1:0] x_ext, y_ext;
   logic                     crit_pos;

   assign x_ext    = CMP_DW'(offset_x);
   assign y_ext    = CMP_DW'(offset_y);
   assign crit_pos = !crit[CRIT_DW-1] && (crit != '0);

`ifdef CIRCLE_CTRL_OCT_SKIP_EN
   oct_mode_t mode_q, mode_d;

   always_comb begin
      oct_last = OCT8;
      oct_next = oct_q + 3'd1;
      unique case (mode_q)
         MODE_AXIS: begin
            oct_last = OCT6;
            oct_next = (oct_q == OCT1) ? OCT2 : oct_q + 3'd2;
         end
         MODE_DIAG: begin
            oct_last = OCT7;
            oct_next = oct_q + 3'd2;
         end
         MODE_ORIGIN: begin
            oct_last = OCT1;
            oct_next = OCT1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) mode_q <= MODE_FULL;
      else         mode_q <= mode_d;
   end
`else
   assign oct_last = OCT8;
   assign oct_next = oct_q + 3'd1;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         oct_q   <= OCT1;
      end else begin
         state_q <= state_d;
         oct_q   <= oct_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      oct_d       = oct_q;
`ifdef CIRCLE_CTRL_OCT_SKIP_EN
      mode_d      = mode_q;
`endif
      done        = 1'b0;
      octant_sel  = 3'd0;
      plot_en     = 1'b0;
      load_x_init = 1'b0;
      load_y_init = 1'b0;
      load_crit   = 1'b0;
      dec_x       = 1'b0;
      inc_y       = 1'b0;
      load_x_next = 1'b0;
      load_y_next = 1'b0;
      calc_crit   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_INIT;
         end
         ST_INIT: begin
            load_x_init = 1'b1;
            load_y_init = 1'b1;
            load_crit   = 1'b1;
            state_d     = ST_CHECK;
         end
         ST_CHECK: begin
            if (y_ext <= x_ext) begin
               state_d = ST_DRAW;
               oct_d   = OCT1;
`ifdef CIRCLE_CTRL_OCT_SKIP_EN
               mode_d  = oct_mode(offset_x == '0, offset_y == '0, x_ext == y_ext);
`endif
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DRAW: begin
            plot_en    = 1'b1;
            octant_sel = oct_q;
            if (oct_q == oct_last) begin
               state_d = ST_CALC;
               oct_d   = OCT1;
            end else begin
               oct_d   = oct_next;
            end
         end
         ST_CALC: begin
            inc_y   = 1'b1;
            dec_x   = crit_pos;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            load_x_next = 1'b1;
            load_y_next = 1'b1;
            calc_crit   = 1'b1;
            state_d     = ST_CHECK;
         end
         ST_DONE: begin
            done = 1'b1;
            if (!start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire
